mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- RV32M multiply/divide unit controller; sits between the EX-stage issue logic and the combinational Booth/Wallace multiplier (`mult`, W=32).
- Decodes funct3 and drives the multiplier sign flags (`i_x_sign`, `i_y_sign`) from registered operands.
- Registers the high or low product word.
- Contains its own iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
- Uses a valid/ready handshake on both sides, so the pipeline stalls while the unit is busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported, to match `mult`.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous kill of any in-flight operation.
- i_valid  input  1  operation request.
- o_ready  output  1  unit can accept a request; high only in IDLE.
- i_funct3  input  3  RV32M funct3.
- i_rs1  input  XLEN  dividend / multiplicand.
- i_rs2  input  XLEN  divisor / multiplier.
- o_valid  output  1  result valid.
- i_res_ready  input  1  consumer accepts the result.
- o_result  output  XLEN  result.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, `i_rst_n`=0):
  - state=IDLE; o_valid=0; o_result=0; o_busy=0; o_ready=1.
  - All operand, counter and remainder registers cleared.
  - Reset mid-operation abandons the operation immediately, with no output.
- Accept: on a rising edge with i_valid & o_ready, latch i_funct3, i_rs1 and i_rs2.
- funct3 decode:
  - 000 MUL: low word, signs don't care.
  - 001 MULH: signed x signed, high word.
  - 010 MULHSU: x signed, y unsigned, high word.
  - 011 MULHU: unsigned, high word.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL (funct3[2]=0) or DIV (funct3[2]=1) on accept.
  - MUL: `mult` is driven from the latched operands. Next edge: o_result <= lo (MUL) or hi (others); o_valid <= 1; -> DONE. Latency: accept at edge N, o_valid high after edge N+2.
  - DIV:
    - On entry, take the magnitude of each operand for signed ops.
    - 32 iterations, one per edge, MSB first: shift remainder left and bring in the next dividend bit; subtract the divisor; if non-negative keep it and set the quotient bit to 1, else restore and set 0.
    - A 5-bit counter counts 31 down to 0; -> FIX when the counter reaches 0.
  - FIX:
    - Apply sign: quotient negated if operand signs differ (signed ops); remainder takes the dividend's sign.
    - Select quotient or remainder; o_valid <= 1; -> DONE.
    - Latency: accept at edge N, o_valid after edge N+34.
  - DONE: o_valid and o_result held stable until i_res_ready=1 at an edge; then o_valid <= 0 and -> IDLE. No back-to-back accept in the same edge.
- RISC-V special cases, produced by the normal path and checked:
  - Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = dividend.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit; the divider datapath is 33 bits wide, so it does not overflow.
- i_flush:
  - Any state -> IDLE at the next edge; o_valid <= 0.
  - A flush asserted together with i_valid in IDLE wins: the request is not accepted.
- o_result changes only on the edge that sets o_valid.

Optional Feature:
- Macro: MDU_FAST_DIV_EN.
- Defined: in DIV, the first DIV cycle detects divisor==0 or signed overflow and goes straight to FIX with the result preloaded. Latency: accept at edge N, o_valid after edge N+2.
- Not defined: special cases take the full 34-cycle path, with identical result values.

Test Plan:
- MUL 0x00000007 x 0xFFFFFFFD (funct3=000) -> o_result=0xFFFFFFEB; o_valid exactly 2 edges after accept.
- MULH / MULHSU / MULHU with 0x80000000 x 0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; latency 34 edges, o_ready=0 throughout.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of same -> 0; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Check 2-edge latency with MDU_FAST_DIV_EN defined, 34 without.
- Hold i_res_ready=0 for 5 cycles after o_valid -> o_valid and o_result stable. Then i_res_ready=1 -> IDLE, o_ready=1 on the next cycle.
- Assert i_flush at iteration 10 of a DIV, and separately assert i_rst_n=0 mid-MUL -> IDLE, o_valid stays 0, next accepted MUL 3x4 returns 12 correctly.

Source files
------------

// File: rtl/mdu_ctrl.sv
// RV32M multiply/divide controller: drives the combinational multiplier and
// runs a radix-2 restoring divider. Optional early-out divide: MDU_FAST_DIV_EN.
module mdu_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic            o_valid,
   input  logic            i_res_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy
);
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t            r_state;
   logic [2:0]        r_funct3;
   logic [XLEN-1:0]   r_rs1, r_rs2;
   logic [2*XLEN-1:0] r_prod;
   logic              r_mul_ph, r_div_init;
   logic [XLEN-1:0]   r_quot, r_rem, r_dvs;
   logic [4:0]        r_cnt;
   logic              r_neg_q, r_neg_r;
   logic              r_valid;
   logic [XLEN-1:0]   r_result;

   logic              w_x_sign, w_y_sign;
   logic [2*XLEN-1:0] w_prod;
   logic              w_sgn_op, w_a_neg, w_b_neg, w_div0;
   logic [XLEN-1:0]   w_a_mag, w_b_mag;
   logic [XLEN:0]     w_rem_sh;
   logic              w_ge;
   logic [XLEN-1:0]   w_rem_nx, w_q_fix, w_r_fix;

   assign o_valid  = r_valid;
   assign o_result = r_result;
   assign o_ready  = (r_state == S_IDLE);
   assign o_busy   = (r_state != S_IDLE);

   assign w_x_sign = (r_funct3[1:0] == 2'b01) || (r_funct3[1:0] == 2'b10);
   assign w_y_sign = (r_funct3[1:0] == 2'b01);

   mult #(.W(XLEN)) u_mult (
      .i_x      (r_rs1),
      .i_y      (r_rs2),
      .i_x_sign (w_x_sign),
      .i_y_sign (w_y_sign),
      .o_p      (w_prod)
   );

   assign w_sgn_op = ~r_funct3[0];
   assign w_a_neg  = w_sgn_op & r_rs1[XLEN-1];
   assign w_b_neg  = w_sgn_op & r_rs2[XLEN-1];
   assign w_a_mag  = w_a_neg ? -r_rs1 : r_rs1;
   assign w_b_mag  = w_b_neg ? -r_rs2 : r_rs2;
   assign w_div0   = (r_rs2 == '0);

   // Shifted remainder is one bit wider than the divisor so |INT_MIN| fits.
   assign w_rem_sh = {r_rem, r_quot[XLEN-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
   assign w_rem_nx = w_ge ? (w_rem_sh[XLEN-1:0] - r_dvs) : w_rem_sh[XLEN-1:0];
   assign w_q_fix  = r_neg_q ? -r_quot : r_quot;
   assign w_r_fix  = r_neg_r ? -r_rem : r_rem;

`ifdef MDU_FAST_DIV_EN
   logic w_ovf;
   assign w_ovf = w_sgn_op & (r_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&r_rs2);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_funct3   <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_prod     <= '0;
         r_mul_ph   <= 1'b0;
         r_div_init <= 1'b0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_dvs      <= '0;
         r_cnt      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_valid    <= 1'b0;
         r_result   <= '0;
      end else if (i_flush) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_valid) begin
               r_funct3   <= i_funct3;
               r_rs1      <= i_rs1;
               r_rs2      <= i_rs2;
               r_mul_ph   <= 1'b0;
               r_div_init <= 1'b1;
               r_state    <= i_funct3[2] ? S_DIV : S_MUL;
            end
            // First MUL cycle registers the full product, second selects the word.
            S_MUL: if (!r_mul_ph) begin
               r_prod   <= w_prod;
               r_mul_ph <= 1'b1;
            end else begin
               r_result <= (r_funct3[1:0] == 2'b00) ? r_prod[XLEN-1:0] : r_prod[2*XLEN-1:XLEN];
               r_valid  <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DIV: if (r_div_init) begin
               r_div_init <= 1'b0;
               r_rem      <= '0;
               r_cnt      <= 5'd31;
               r_quot     <= w_a_mag;
               r_dvs      <= w_b_mag;
               // Divide by zero must yield all-ones regardless of operand signs.
               r_neg_q    <= (w_a_neg ^ w_b_neg) & ~w_div0;
               r_neg_r    <= w_a_neg;
`ifdef MDU_FAST_DIV_EN
               if (w_div0 || w_ovf) begin
                  r_quot  <= w_div0 ? '1 : r_rs1;
                  r_rem   <= w_div0 ? r_rs1 : '0;
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
                  r_state <= S_FIX;
               end
`endif
            end else begin
               r_quot <= {r_quot[XLEN-2:0], w_ge};
               r_rem  <= w_rem_nx;
               if (r_cnt == 5'd0) r_state <= S_FIX;
               else               r_cnt   <= r_cnt - 5'd1;
            end
            S_FIX: begin
               r_result <= r_funct3[1] ? w_r_fix : w_q_fix;
               r_valid  <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DONE: if (i_res_ready) begin
               r_valid <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// Combinational W x W multiplier with per-operand signedness; full 2W product.
module mult #(
   parameter int W = 32
) (
   input  logic [W-1:0]   i_x,
   input  logic [W-1:0]   i_y,
   input  logic           i_x_sign,
   input  logic           i_y_sign,
   output logic [2*W-1:0] o_p
);
   logic [2*W-1:0] w_x_ext, w_y_ext;

   // Sign-extending to 2W and truncating gives the exact product for all sign modes.
   assign w_x_ext = {{W{i_x_sign & i_x[W-1]}}, i_x};
   assign w_y_ext = {{W{i_y_sign & i_y[W-1]}}, i_y};
   assign o_p     = w_x_ext * w_y_ext;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed RV32M vectors, results and latency.
module tb_mdu_ctrl;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_flush = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [2:0]  i_funct3 = '0;
   logic [31:0] i_rs1 = '0;
   logic [31:0] i_rs2 = '0;
   logic        o_valid;
   logic        i_res_ready = 1'b1;
   logic [31:0] o_result;
   logic        o_busy;

   mdu_ctrl #(.XLEN(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(o_ready), .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2),
      .o_valid(o_valid), .i_res_ready(i_res_ready), .o_result(o_result), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

`ifdef MDU_FAST_DIV_EN
   localparam int SPC_LAT = 2;
`else
   localparam int SPC_LAT = 34;
`endif

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_tot = 0;
   logic prev_v = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   // Monitor: compare on the first cycle each result is presented.
   always @(negedge i_clk) begin
      if (o_valid === 1'b1 && !prev_v) begin
         if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, "_res"}, o_result, e.res);
            chk({e.name, "_lat"}, cyc - e.acc, e.lat);
         end
      end
      prev_v = (o_valid === 1'b1);
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge i_clk);
      while (!o_ready && n < 100) begin @(negedge i_clk); n++; end
   endtask

   task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit chk_rdy);
      int n = 0;
      bit rdy_bad = 1'b0;
      exp_t e;
      wait_ready();
      i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b;
      @(negedge i_clk);
      i_valid = 1'b0;
      e.res = exp; e.lat = lat; e.acc = cyc; e.name = nm;
      q.push_back(e);
      while (q.size() != 0 && n < 100) begin
         if (o_ready) rdy_bad = 1'b1;
         @(negedge i_clk);
         n++;
      end
      if (q.size() != 0) begin
         chk({nm, "_timeout"}, 32'd1, 32'd0);
         q.delete();
      end
      if (chk_rdy) chk({nm, "_rdy_low"}, {31'd0, rdy_bad}, 32'd0);
   endtask

   initial begin
      int n;
      bit seen;
      #3;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;

      do_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1'b1);
      do_op("mulh",   3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b1);
      do_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b1);
      do_op("mulhu",  3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 2, 1'b1);
      do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b1);
      do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b1);
      do_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        34, 1'b1);
      do_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         34, 1'b1);
      do_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, 1'b1);
      do_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT, 1'b1);
      do_op("divu_z",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT, 1'b1);
      do_op("remu_z",   3'b111, 32'd5,         32'd0,         32'd5,         SPC_LAT, 1'b1);
      do_op("div_negz", 3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, SPC_LAT, 1'b1);
      do_op("rem_negz", 3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, SPC_LAT, 1'b1);

      // Consumer back-pressure: result must hold until accepted.
      i_res_ready = 1'b0;
      do_op("hold", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         chk("hold_valid", {31'd0, o_valid}, 32'd1);
         chk("hold_result", o_result, 32'hFFFF_FFEB);
      end
      i_res_ready = 1'b1;
      @(negedge i_clk);
      chk("release_valid", {31'd0, o_valid}, 32'd0);
      chk("release_ready", {31'd0, o_ready}, 32'd1);

      // Flush at iteration ~10 of a divide.
      wait_ready();
      i_valid = 1'b1; i_funct3 = 3'b101; i_rs1 = 32'd1000; i_rs2 = 32'd3;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (10) @(negedge i_clk);
      i_flush = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      chk("flush_ready", {31'd0, o_ready}, 32'd1);
      chk("flush_valid", {31'd0, o_valid}, 32'd0);
      seen = 1'b0;
      for (n = 0; n < 40; n++) begin
         @(negedge i_clk);
         if (o_valid) seen = 1'b1;
      end
      chk("flush_no_valid", {31'd0, seen}, 32'd0);

      // Flush wins over a simultaneous request in IDLE.
      i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'b000; i_rs1 = 32'd1; i_rs2 = 32'd1;
      @(negedge i_clk);
      i_valid = 1'b0; i_flush = 1'b0;
      chk("flush_vs_valid_busy", {31'd0, o_busy}, 32'd0);
      do_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 2, 1'b1);

      // Async reset in the middle of a multiply.
      wait_ready();
      i_valid = 1'b1; i_funct3 = 3'b000; i_rs1 = 32'd9; i_rs2 = 32'd9;
      @(negedge i_clk);
      i_valid = 1'b0;
      chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
      chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      seen = 1'b0;
      for (n = 0; n < 4; n++) begin
         @(negedge i_clk);
         if (o_valid) seen = 1'b1;
      end
      chk("rst_no_valid", {31'd0, seen}, 32'd0);
      do_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 2, 1'b1);

      repeat (3) @(negedge i_clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
